// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the scoreboarded register bank
// Contents:
//   DEF_DATA_W / DEF_ADDR_W / DEF_NUM_RD : default geometry of the bank
//   MAX_ADDR_W / MAX_NREGS / POP_W       : upper bound used by the popcount helper
//   nregs(addr_w)                        : number of registers for an address width
//   popcount(v)                          : number of set bits in a busy vector
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_NUM_RD = 2;

    // popcount works on a fixed-width vector; callers zero-extend their busy vector
    localparam int MAX_ADDR_W = 8;
    localparam int MAX_NREGS  = 1 << MAX_ADDR_W;
    localparam int POP_W      = MAX_ADDR_W + 1;

    function automatic int nregs(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_NREGS-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_NREGS; i++) begin
            c = c + POP_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational source port with write-through bypass and hazard flag
// Ports:
//   rd_addr   : source register select
//   mem_flat  : flattened storage, register n at [n*DATA_W +: DATA_W]
//   busy_vec  : scoreboard state
//   bwr       : per-register "being written this cycle" vector (r0 already excluded if zeroed)
//   wr_data   : writeback data forwarded on a bypass hit
//   rd_data   : source value
//   rd_hazard : source is busy and its writeback is not arriving this cycle
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int ZERO_R0 = 0
) (
    input  logic [ADDR_W-1:0]                    rd_addr,
    input  logic [(1<<ADDR_W)*DATA_W-1:0]        mem_flat,
    input  logic [(1<<ADDR_W)-1:0]               busy_vec,
    input  logic [(1<<ADDR_W)-1:0]               bwr,
    input  logic [DATA_W-1:0]                    wr_data,
    output logic [DATA_W-1:0]                    rd_data,
    output logic                                 rd_hazard
);

    logic is_zero;
    logic hit;

    always_comb begin
        is_zero = (ZERO_R0 != 0) && (rd_addr == '0);
        hit     = bwr[rd_addr];
        if (is_zero) begin
            rd_data = '0;
        end else if (hit) begin
            rd_data = wr_data;
        end else begin
            rd_data = mem_flat[rd_addr*DATA_W +: DATA_W];
        end
        // a busy source whose result is on the writeback bus right now is already satisfied
        rd_hazard = busy_vec[rd_addr] && !hit;
    end

endmodule

// File: rtl/regfile_sb_bank.sv
// rtl/regfile_sb_bank.sv - parametrised register bank with bypassed read ports and busy scoreboard
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data   : writeback port
//   rd_addr, rd_data          : NUM_RD packed source ports (port i at slice i)
//   rd_hazard                 : per-port RAW hazard
//   issue_valid, issue_dest   : instruction presented by decode
//   issue_ready               : instruction may issue this cycle (no RAW, no WAW)
//   busy_vec, busy_count      : scoreboard state and its popcount
module regfile_sb_bank
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_RD  = DEF_NUM_RD,
    parameter int ZERO_R0 = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
    output logic [NUM_RD*DATA_W-1:0]    rd_data,
    output logic [NUM_RD-1:0]           rd_hazard,
    input  logic                        issue_valid,
    input  logic [ADDR_W-1:0]           issue_dest,
    output logic                        issue_ready,
    output logic [(1<<ADDR_W)-1:0]      busy_vec,
    output logic [ADDR_W:0]             busy_count
);

    localparam int NREGS = nregs(ADDR_W);

    logic [DATA_W-1:0]       mem [NREGS];
    logic [NREGS*DATA_W-1:0] mem_flat;
    logic [NREGS-1:0]        busy_q;
    logic [NREGS-1:0]        busy_d;
    logic [NREGS-1:0]        bwr;
    logic [NREGS-1:0]        set_v;
    logic [ADDR_W:0]         count_q;
    logic                    wr_keep;
    logic                    waw;
    logic [MAX_NREGS-1:0]    pop_in;
    logic [POP_W-1:0]        pop_full;

    always_comb begin
        for (int n = 0; n < NREGS; n++) begin
            mem_flat[n*DATA_W +: DATA_W] = mem[n];
            bwr[n] = wr_en && (wr_addr == ADDR_W'(n)) && !((ZERO_R0 != 0) && (n == 0));
        end
        wr_keep = |bwr;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            regfile_rd_port #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .ZERO_R0(ZERO_R0)
            ) u_port (
                .rd_addr  (rd_addr[gi*ADDR_W +: ADDR_W]),
                .mem_flat (mem_flat),
                .busy_vec (busy_q),
                .bwr      (bwr),
                .wr_data  (wr_data),
                .rd_data  (rd_data[gi*DATA_W +: DATA_W]),
                .rd_hazard(rd_hazard[gi])
            );
        end
    endgenerate

    always_comb begin
        waw         = busy_q[issue_dest] && !bwr[issue_dest];
        issue_ready = issue_valid && !(|rd_hazard) && !waw;
        for (int n = 0; n < NREGS; n++) begin
            set_v[n] = issue_ready && (issue_dest == ADDR_W'(n)) && !((ZERO_R0 != 0) && (n == 0));
        end
        // set dominates clear so a same-cycle writeback and re-issue leaves the register busy
        busy_d = set_v | (busy_q & ~bwr);
        pop_in = '0;
        pop_in[NREGS-1:0] = busy_d;
        pop_full = popcount(pop_in);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NREGS; n++) begin
                mem[n] <= '0;
            end
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= pop_full[ADDR_W:0];
            if (wr_keep) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    assign busy_vec   = busy_q;
    assign busy_count = count_q;

endmodule

// File: tb/tb_regfile_sb_bank.sv
// tb/tb_regfile_sb_bank.sv - self-checking bench for regfile_sb_bank (plain and zeroed-r0 builds)
module tb_regfile_sb_bank;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  ra0 = '0;
    logic [3:0]  ra1 = '0;
    logic        issue_valid = 1'b0;
    logic [3:0]  issue_dest = '0;

    logic [7:0]  rd_addr;
    assign rd_addr = {ra1, ra0};

    logic [63:0] rd_data [2];
    logic [1:0]  rd_hazard [2];
    logic        issue_ready [2];
    logic [15:0] busy_vec [2];
    logic [4:0]  busy_count [2];

    regfile_sb_bank #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .ZERO_R0(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data[0]), .rd_hazard(rd_hazard[0]),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready[0]),
        .busy_vec(busy_vec[0]), .busy_count(busy_count[0])
    );

    regfile_sb_bank #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data[1]), .rd_hazard(rd_hazard[1]),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready[1]),
        .busy_vec(busy_vec[1]), .busy_count(busy_count[1])
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: k=0 plain build, k=1 zeroed-r0 build
    logic [31:0] ref_mem  [2][NR];
    bit          ref_busy [2][NR];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_bwr(int k, int n);
        return wr_en && (int'(wr_addr) == n) && !(k == 1 && n == 0);
    endfunction

    function automatic logic [31:0] m_rd(int k, int a);
        if (k == 1 && a == 0) return 32'h0;
        if (m_bwr(k, a)) return wr_data;
        return ref_mem[k][a];
    endfunction

    function automatic bit m_hz(int k, int a);
        return ref_busy[k][a] && !m_bwr(k, a);
    endfunction

    function automatic bit m_ready(int k);
        return issue_valid && !m_hz(k, int'(ra0)) && !m_hz(k, int'(ra1))
               && !(ref_busy[k][issue_dest] && !m_bwr(k, int'(issue_dest)));
    endfunction

    function automatic logic [15:0] m_vec(int k);
        logic [15:0] v;
        for (int n = 0; n < NR; n++) v[n] = ref_busy[k][n];
        return v;
    endfunction

    function automatic int m_cnt(int k);
        int c = 0;
        for (int n = 0; n < NR; n++) c += int'(ref_busy[k][n]);
        return c;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int n = 0; n < NR; n++) begin
                ref_mem[k][n]  = '0;
                ref_busy[k][n] = 1'b0;
            end
    endtask

    task automatic check_comb();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rd_data0[k%0d]", k), {32'h0, rd_data[k][31:0]},  {32'h0, m_rd(k, int'(ra0))});
            check($sformatf("rd_data1[k%0d]", k), {32'h0, rd_data[k][63:32]}, {32'h0, m_rd(k, int'(ra1))});
            check($sformatf("rd_hazard[k%0d]", k), 64'(rd_hazard[k]),
                  64'({m_hz(k, int'(ra1)), m_hz(k, int'(ra0))}));
            check($sformatf("issue_ready[k%0d]", k), 64'(issue_ready[k]), 64'(m_ready(k)));
        end
    endtask

    task automatic check_state();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("busy_vec[k%0d]", k), 64'(busy_vec[k]), 64'(m_vec(k)));
            check($sformatf("busy_count[k%0d]", k), 64'(busy_count[k]), 64'(m_cnt(k)));
        end
    endtask

    // inputs are already driven (after a negedge); check, clock, advance model, check, return at negedge
    task automatic cyc();
        bit acc [2];
        #1;
        check_comb();
        for (int k = 0; k < 2; k++) acc[k] = m_ready(k);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < NR; n++) begin
                bit set_n = acc[k] && (int'(issue_dest) == n) && !(k == 1 && n == 0);
                ref_busy[k][n] = set_n | (ref_busy[k][n] & ~m_bwr(k, n));
            end
            if (wr_en && !(k == 1 && wr_addr == 0)) ref_mem[k][wr_addr] = wr_data;
        end
        #1;
        check_state();
        @(negedge clk);
    endtask

    task automatic drive(input bit we, input int wa, input logic [31:0] wd,
                         input int a0, input int a1, input bit iv, input int id);
        wr_en = we; wr_addr = 4'(wa); wr_data = wd;
        ra0 = 4'(a0); ra1 = 4'(a1); issue_valid = iv; issue_dest = 4'(id);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_state();
        check_comb();
        check("reset_rd_data0", {32'h0, rd_data[0][31:0]}, 64'h0);
        check("reset_ready_follows_valid", 64'(issue_ready[0]), 64'(issue_valid));
        rst = 1'b0;
        @(negedge clk);

        // 1: write then read back
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);  cyc();
        drive(0, 0, 32'h0, 5, 0, 0, 0);         #1;
        check("t1_rd_data0", {32'h0, rd_data[0][31:0]}, 64'hDEADBEEF);
        check("t1_rd_hazard", 64'(rd_hazard[0]), 64'h0);
        cyc();

        // 2: same-cycle bypass on port 1
        drive(1, 7, 32'h12345678, 0, 7, 0, 0);  #1;
        check("t2_bypass", {32'h0, rd_data[0][63:32]}, 64'h12345678);
        cyc();

        // 3: RAW on r3 held until writeback, which bypasses
        drive(0, 0, 32'h0, 0, 0, 1, 3);         cyc();
        drive(0, 0, 32'h0, 3, 0, 1, 8);         #1;
        check("t3_hazard", 64'(rd_hazard[0][0]), 64'h1);
        check("t3_stall", 64'(issue_ready[0]), 64'h0);
        cyc();
        cyc();
        drive(1, 3, 32'hA5A5_0003, 3, 0, 1, 8); #1;
        check("t3_wb_ready", 64'(issue_ready[0]), 64'h1);
        check("t3_wb_bypass", {32'h0, rd_data[0][31:0]}, 64'hA5A5_0003);
        cyc();
        drive(1, 8, 32'h8888_8888, 0, 0, 0, 0); cyc();

        // 4: WAW on r9, then simultaneous writeback + re-issue keeps it busy
        drive(0, 0, 32'h0, 0, 0, 1, 9);         cyc();
        drive(0, 0, 32'h0, 0, 0, 1, 9);         #1;
        check("t4_waw_stall", 64'(issue_ready[0]), 64'h0);
        cyc();
        drive(1, 9, 32'h0000_0909, 0, 0, 1, 9); #1;
        check("t4_waw_accept", 64'(issue_ready[0]), 64'h1);
        cyc();
        check("t4_still_busy", 64'(busy_vec[0][9]), 64'h1);
        drive(1, 9, 32'h0000_0999, 0, 0, 0, 0); cyc();

        // 5: zeroed r0 ignores writes and never goes busy
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);  cyc();
        drive(0, 0, 32'h0, 0, 0, 1, 0);         #1;
        check("t5_r0_zero", {32'h0, rd_data[1][31:0]}, 64'h0);
        check("t5_r0_plain", {32'h0, rd_data[0][31:0]}, 64'hFFFFFFFF);
        cyc();
        check("t5_busy_vec_z", 64'(busy_vec[1]), 64'h0);
        check("t5_busy_cnt_z", 64'(busy_count[1]), 64'h0);
        drive(1, 0, 32'h0, 0, 0, 0, 0);         cyc();

        // 6: three busy registers, then asynchronous reset mid-cycle
        drive(0, 0, 32'h0, 0, 0, 1, 1);         cyc();
        drive(0, 0, 32'h0, 0, 0, 1, 2);         cyc();
        drive(0, 0, 32'h0, 0, 0, 1, 4);         cyc();
        check("t6_count3", 64'(busy_count[0]), 64'h3);
        drive(0, 0, 32'h0, 5, 7, 0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("t6_rst_vec", 64'(busy_vec[0]), 64'h0);
        check("t6_rst_cnt", 64'(busy_count[0]), 64'h0);
        check("t6_rst_rd", rd_data[0], 64'h0);
        check_comb();
        #1 rst = 1'b0;
        @(negedge clk);
        // in-flight writeback after reset writes data but leaves busy clear
        drive(1, 1, 32'h1111_1111, 1, 0, 0, 0); cyc();
        check("t6_late_wb_busy", 64'(busy_vec[0][1]), 64'h0);

        // randomized traffic against the model
        for (int t = 0; t < 400; t++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 7));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb_bank.md
Name: regfile_sb_bank

Overview:
Parametrised successor to the 16x32 register bank and its two fixed source muxes. Provides synchronous write, NUM_RD combinational read ports with write-through bypass, and a per-register busy scoreboard. The scoreboard gates instruction issue on RAW and WAW hazards. The block sits between decode (source/destination fields) and the ALU/LDR writeback path.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 4, register address width; NREGS = 2**ADDR_W
NUM_RD, 2, number of read (source) ports
ZERO_R0, 0, 1 = register 0 reads as zero, ignores writes, and is never busy

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback destination
wr_data  in  DATA_W  writeback data (from LDR mux)
rd_addr  in  NUM_RD*ADDR_W  source selects; port i = bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  source data; port i = bits [i*DATA_W +: DATA_W]
rd_hazard  out  NUM_RD  port i source is busy and not being written this cycle
issue_valid  in  1  decode presents an instruction
issue_dest  in  ADDR_W  destination of the presented instruction
issue_ready  out  1  instruction may issue this cycle
busy_vec  out  2**ADDR_W  scoreboard state, bit n = register n busy
busy_count  out  ADDR_W+1  popcount of busy_vec

Behaviour:
- Reset (async, rst=1): all registers = 0; busy_vec = 0; busy_count = 0. Combinational outputs follow, so rd_data = 0, rd_hazard = 0, and issue_ready = issue_valid.
- Write: at posedge clk with wr_en=1, mem[wr_addr] <= wr_data. When ZERO_R0=1 and wr_addr=0, the write is dropped.
- Read: rd_data[i] is combinational with 0-cycle latency.
  - If wr_en && wr_addr==rd_addr[i] (and not the ZERO_R0 r0 case), rd_data[i] = wr_data (bypass).
  - Otherwise rd_data[i] = mem[rd_addr[i]].
  - ZERO_R0=1 and rd_addr[i]=0 gives 0.
- Bypass matching: bwr[n] = wr_en && wr_addr==n, excluding n=0 when ZERO_R0=1.
- Hazard: rd_hazard[i] = busy[rd_addr[i]] && !bwr[rd_addr[i]].
- waw = busy[issue_dest] && !bwr[issue_dest].
- issue_ready = issue_valid && !(|rd_hazard) && !waw. Issue is accepted in a cycle when issue_ready=1.
- Scoreboard update at posedge, per register n:
  - set_n = accepted && issue_dest==n (excluding r0 when ZERO_R0=1)
  - clr_n = bwr[n]
  - set wins over clr: a same-cycle writeback and re-issue to the same register leaves it busy.
  - busy[n] <= set_n | (busy[n] & ~clr_n).
- Writeback to a non-busy register is legal: data is written and busy is unaffected.
- Reset asserted mid-operation clears all state immediately. An in-flight writeback arriving after reset deassertion writes data but leaves busy at 0.
- busy_count is registered alongside busy_vec and is consistent with it every cycle.
- No illegal states. Behaviour is fully defined for every input combination.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W/ADDR_W/NUM_RD constants
  - function for NREGS
  - popcount function used for busy_count
- One natural sub-module, regfile_rd_port: a single read port with bypass and hazard logic, generate-instantiated NUM_RD times.
- The scoreboard and storage stay in the top module.

Test Plan:
1. Reset, then write 0xDEADBEEF to r5; next cycle rd_addr0=5 -> rd_data0=0xDEADBEEF, rd_hazard=0.
2. Same-cycle bypass: wr_en=1, wr_addr=7, wr_data=0x12345678, rd_addr1=7 -> rd_data1=0x12345678 in that same cycle.
3. Issue dest=3, then next instruction reads src r3 -> rd_hazard0=1 and issue_ready=0 until writeback of r3. In the writeback cycle issue_ready=1 and rd_data shows the bypassed value.
4. WAW: r9 busy, issue_dest=9 -> issue_ready=0. A simultaneous writeback to r9 with issue_dest=9 accepts issue, and busy_vec[9] stays 1.
5. ZERO_R0=1 build: write 0xFFFFFFFF to r0 -> rd_data=0. Issue_dest=0 -> busy_vec=0 and busy_count=0.
6. Set r1, r2, and r4 busy (busy_count=3), assert rst asynchronously mid-cycle -> busy_vec=0, busy_count=0, and all reads return 0 before the next clock edge.
